// File: rtl/flag_select_ctrl.sv
// flag_select_ctrl
//   Front-end controller that turns raw TinyTapeout button inputs into the
//   flag index used by the flag lookup / VGA colour stage. Fully synchronous
//   on clk: per-button synchroniser, frame-based debounce FSM, press-event
//   generation, wrap-around index arithmetic against max_index, and an
//   optional slideshow auto-advance.
//
// Ports
//   clk        in   pixel clock
//   reset      in   synchronous active-high reset
//   frame_tick in   one-cycle pulse per frame (vertical blanking)
//   btn_clear  in   raw button: index := 0
//   btn_next   in   raw button: index + 1 with wrap
//   btn_prev   in   raw button: index - 1 with wrap
//   btn_load   in   raw button: index := min(load_value, max_index)
//   load_value in   [INDEX_W-1:0] load target, sampled on the event cycle
//   max_index  in   [INDEX_W-1:0] highest valid flag index
//   auto_en    in   slideshow enable (level)
//   index      out  [INDEX_W-1:0] current flag index (registered)
//   changed    out  one-cycle pulse with the first cycle of a new index
//
// Build option
//   FLAG_SELECT_HOLD_REPEAT_EN : when defined, holding next/prev repeats the
//   action after 30 frame ticks, then every 8 ticks.
//
// Debounce FSM (one instance per button, advances on frame_tick only)
//   state        | meaning
//   RELEASED     | button accepted as released
//   PRESS_WAIT   | sync level high, counting ticks before accepting press
//   HELD         | press accepted (event emitted on entry)
//   RELEASE_WAIT | sync level low, counting ticks before accepting release

module flag_select_ctrl #(
  parameter int INDEX_W         = 7,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_clear,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               btn_load,
  input  logic [INDEX_W-1:0] load_value,
  input  logic [INDEX_W-1:0] max_index,
  input  logic               auto_en,
  output logic [INDEX_W-1:0] index,
  output logic               changed
);

  localparam int NB    = 4;
  localparam int B_CLR = 0;
  localparam int B_NXT = 1;
  localparam int B_PRV = 2;
  localparam int B_LD  = 3;

  // Down-counters hold the number of further ticks still required.
  localparam logic [3:0] DB_INIT   = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [9:0] AUTO_INIT = 10'(AUTO_FRAMES);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1, sync2, sync3;

  db_state_t     db_state     [NB];
  db_state_t     db_state_nxt [NB];
  logic [3:0]    db_left      [NB];
  logic [3:0]    db_left_nxt  [NB];
  logic [NB-1:0] press_evt;

  logic          evt_clear, evt_next, evt_prev, evt_load;
  logic          any_btn_evt;
  logic [9:0]    auto_left;
  logic          auto_evt;

  logic [INDEX_W-1:0] idx_inc, idx_dec, idx_ld, idx_nxt;

  assign btn_raw = {btn_load, btn_prev, btn_next, btn_clear};

  // Two metastability flops plus a third stage that provides the sync level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (reset) begin
        db_state[b] <= RELEASED;
        db_left[b]  <= '0;
      end else begin
        db_state[b] <= db_state_nxt[b];
        db_left[b]  <= db_left_nxt[b];
      end
    end
  end

  always_comb begin
    press_evt = '0;
    for (int b = 0; b < NB; b++) begin
      db_state_nxt[b] = db_state[b];
      db_left_nxt[b]  = db_left[b];
      if (frame_tick) begin
        case (db_state[b])
          RELEASED: begin
            if (sync3[b]) begin
              if (DEBOUNCE_FRAMES == 1) begin
                db_state_nxt[b] = HELD;
                press_evt[b]    = 1'b1;
              end else begin
                db_state_nxt[b] = PRESS_WAIT;
                db_left_nxt[b]  = DB_INIT;
              end
            end
          end
          PRESS_WAIT: begin
            if (!sync3[b]) begin
              db_state_nxt[b] = RELEASED;
            end else if (db_left[b] == 4'd1) begin
              db_state_nxt[b] = HELD;
              press_evt[b]    = 1'b1;
            end else begin
              db_left_nxt[b] = db_left[b] - 4'd1;
            end
          end
          HELD: begin
            if (!sync3[b]) begin
              if (DEBOUNCE_FRAMES == 1) begin
                db_state_nxt[b] = RELEASED;
              end else begin
                db_state_nxt[b] = RELEASE_WAIT;
                db_left_nxt[b]  = DB_INIT;
              end
            end
          end
          RELEASE_WAIT: begin
            if (sync3[b]) begin
              db_state_nxt[b] = HELD;
            end else if (db_left[b] == 4'd1) begin
              db_state_nxt[b] = RELEASED;
            end else begin
              db_left_nxt[b] = db_left[b] - 4'd1;
            end
          end
          default: db_state_nxt[b] = RELEASED;
        endcase
      end
    end
  end

`ifdef FLAG_SELECT_HOLD_REPEAT_EN
  localparam logic [4:0] REP_FIRST  = 5'd30;
  localparam logic [4:0] REP_PERIOD = 5'd8;

  // Slot 0 tracks btn_next, slot 1 tracks btn_prev.
  logic [4:0] rep_left [2];
  logic [1:0] rep_evt;
  logic [1:0] rep_count;

  always_comb begin
    rep_evt   = '0;
    rep_count = '0;
    for (int r = 0; r < 2; r++) begin
      // Only ticks that keep the button in HELD count; the tick that drops
      // into RELEASE_WAIT does not.
      rep_count[r] = frame_tick && (db_state[r+1] == HELD) &&
                     (db_state_nxt[r+1] == HELD);
      rep_evt[r]   = rep_count[r] && (rep_left[r] == 5'd1);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (reset || (db_state[r+1] != HELD)) begin
        rep_left[r] <= REP_FIRST;
      end else if (rep_count[r]) begin
        if (rep_left[r] == 5'd1) rep_left[r] <= REP_PERIOD;
        else                     rep_left[r] <= rep_left[r] - 5'd1;
      end
    end
  end

  assign evt_next    = press_evt[B_NXT] | rep_evt[0];
  assign evt_prev    = press_evt[B_PRV] | rep_evt[1];
  assign any_btn_evt = (|press_evt) | (|rep_evt);
`else
  assign evt_next    = press_evt[B_NXT];
  assign evt_prev    = press_evt[B_PRV];
  assign any_btn_evt = |press_evt;
`endif

  assign evt_clear = press_evt[B_CLR];
  assign evt_load  = press_evt[B_LD];

  // Slideshow timer: a press restarts the full interval so a manual step is
  // never followed immediately by an automatic one.
  always_ff @(posedge clk) begin
    if (reset || !auto_en || any_btn_evt) begin
      auto_left <= AUTO_INIT;
    end else if (frame_tick) begin
      if (auto_left == 10'd1) auto_left <= AUTO_INIT;
      else                    auto_left <= auto_left - 10'd1;
    end
  end

  assign auto_evt = auto_en && frame_tick && (auto_left == 10'd1);

  // An index above max_index (max_index shrank) is treated as out of range:
  // next goes to 0, prev goes to max_index.
  assign idx_inc = (index < max_index) ? index + INDEX_W'(1) : '0;
  assign idx_dec = ((index == '0) || (index > max_index)) ? max_index
                                                          : index - INDEX_W'(1);
  assign idx_ld  = (load_value > max_index) ? max_index : load_value;

  always_comb begin
    idx_nxt = index;
    if (evt_clear)     idx_nxt = '0;
    else if (evt_next) idx_nxt = idx_inc;
    else if (evt_prev) idx_nxt = idx_dec;
    else if (evt_load) idx_nxt = idx_ld;
    else if (auto_evt) idx_nxt = idx_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index   <= '0;
      changed <= 1'b0;
    end else begin
      index   <= idx_nxt;
      changed <= (idx_nxt != index);
    end
  end

endmodule

// File: tb/tb_flag_select_ctrl.sv
module tb_flag_select_ctrl;

  localparam int INDEX_W = 7;

`ifdef FLAG_SELECT_HOLD_REPEAT_EN
  localparam int HOLD_EXP = 3;
`else
  localparam int HOLD_EXP = 1;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_tick;
  logic               btn_clear, btn_next, btn_prev, btn_load;
  logic [INDEX_W-1:0] load_value;
  logic [INDEX_W-1:0] max_index;
  logic               auto_en;
  logic [INDEX_W-1:0] index;
  logic               changed;

  int vectors = 0;
  int errors  = 0;
  int chg_cnt = 0;
  int chg_base;

  flag_select_ctrl #(
    .INDEX_W(INDEX_W),
    .DEBOUNCE_FRAMES(2),
    .AUTO_FRAMES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .btn_clear(btn_clear),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .btn_load(btn_load),
    .load_value(load_value),
    .max_index(max_index),
    .auto_en(auto_en),
    .index(index),
    .changed(changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (changed === 1'b1) chg_cnt = chg_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: 7 idle cycles then a single frame_tick cycle. Returns just
  // after the edge that consumed the tick, so an event's index is visible.
  task automatic frame();
    frame_tick = 1'b0;
    repeat (7) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic release_all();
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    btn_prev  = 1'b0;
    btn_load  = 1'b0;
    frames(3);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    btn_clear  = 1'b0;
    btn_next   = 1'b0;
    btn_prev   = 1'b0;
    btn_load   = 1'b0;
    load_value = '0;
    max_index  = 7'd5;
    auto_en    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("reset_index", index, 0);
    check("reset_changed", changed, 0);

    chg_base = chg_cnt;
    frames(10);
    check("idle_index", index, 0);
    check("idle_changed", chg_cnt - chg_base, 0);

    // load 5 with max 5
    load_value = 7'd5;
    btn_load   = 1'b1;
    frame();
    check("load5_tick1", index, 0);
    frame();
    check("load5_tick2", index, 5);
    check("load5_changed", changed, 1);
    release_all();

    // next at max wraps to 0
    chg_base = chg_cnt;
    btn_next = 1'b1;
    frame();
    check("wrap_tick1", index, 5);
    frame();
    check("wrap_tick2", index, 0);
    check("wrap_changed", changed, 1);
    frame();
    check("wrap_tick3", index, 0);
    check("wrap_pulses", chg_cnt - chg_base, 1);
    release_all();

    // bouncing button never qualifies
    chg_base = chg_cnt;
    for (int f = 0; f < 6; f++) begin
      btn_next = (f % 2 == 0);
      frame();
    end
    btn_next = 1'b0;
    frame();
    check("bounce_index", index, 0);
    check("bounce_pulses", chg_cnt - chg_base, 0);

    // prev from 0 wraps to max, then normal decrement
    btn_prev = 1'b1;
    frames(2);
    check("prev_wrap", index, 5);
    release_all();
    btn_prev = 1'b1;
    frames(2);
    check("prev_dec", index, 4);
    release_all();

    // load clamps to max, then next with index above a shrunken max
    load_value = 7'd9;
    btn_load   = 1'b1;
    frames(2);
    check("load_clamp", index, 5);
    release_all();
    max_index = 7'd3;
    btn_next  = 1'b1;
    frames(2);
    check("next_above_max", index, 0);
    release_all();

    // prev with index above a shrunken max goes to max
    max_index  = 7'd5;
    load_value = 7'd4;
    btn_load   = 1'b1;
    frames(2);
    check("load4", index, 4);
    release_all();
    max_index = 7'd2;
    btn_prev  = 1'b1;
    frames(2);
    check("prev_above_max", index, 2);
    release_all();

    // clear beats next on the same tick
    max_index = 7'd5;
    chg_base  = chg_cnt;
    btn_clear = 1'b1;
    btn_next  = 1'b1;
    frames(2);
    check("clear_over_next", index, 0);
    release_all();
    check("clear_next_pulses", chg_cnt - chg_base, 1);

    // no-op actions do not pulse changed
    chg_base  = chg_cnt;
    btn_clear = 1'b1;
    frames(2);
    release_all();
    max_index = 7'd0;
    btn_next  = 1'b1;
    frames(2);
    release_all();
    check("noop_index", index, 0);
    check("noop_pulses", chg_cnt - chg_base, 0);

    // long hold
    max_index = 7'd5;
    chg_base  = chg_cnt;
    btn_next  = 1'b1;
    frames(40);
    check("hold_index", index, HOLD_EXP);
    release_all();
    check("hold_pulses", chg_cnt - chg_base, HOLD_EXP);

    // next beats prev on the same tick
    btn_next = 1'b1;
    btn_prev = 1'b1;
    frames(2);
    check("next_over_prev", index, HOLD_EXP + 1);
    release_all();

    // reset mid-debounce discards progress
    btn_next = 1'b1;
    frame();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_index", index, 0);
    frame();
    check("midreset_tick1", index, 0);
    frame();
    check("midreset_tick2", index, 1);
    release_all();

    // slideshow: 1,2,0 at ticks 4,8,12
    btn_clear = 1'b1;
    frames(2);
    release_all();
    max_index = 7'd2;
    auto_en   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      frame();
      if (k == 3)  check("auto_t3", index, 0);
      if (k == 4)  check("auto_t4", index, 1);
      if (k == 7)  check("auto_t7", index, 1);
      if (k == 8)  check("auto_t8", index, 2);
      if (k == 12) check("auto_t12", index, 0);
    end

    // auto_en low holds the slideshow
    auto_en = 1'b0;
    frames(6);
    check("auto_off", index, 0);

    // manual next at tick 6 restarts the interval
    auto_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      frame();
      if (k == 4) begin
        check("autob_t4", index, 1);
        btn_next = 1'b1;
      end
      if (k == 6) begin
        check("autob_t6", index, 2);
        btn_next = 1'b0;
      end
      if (k == 8)  check("autob_t8", index, 2);
      if (k == 9)  check("autob_t9", index, 2);
      if (k == 10) check("autob_t10", index, 0);
    end
    auto_en = 1'b0;
    frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
